// File: rtl/impulse_monitor.sv
// impulse_monitor: measures the spacing of rising edges on a pulse stream,
//    declares lock after LOCK_COUNT consecutive periods of EXPECTED_PERIOD
//    cycles, and flags wrong periods and lost streams (gap reaching TIMEOUT).
// Latency: every output is registered and reflects the clock edge at which
//    the triggering input was sampled (one clock after the edge cycle).
// Backpressure: none; the block observes impulse_in every cycle and never stalls.
//
// Ports:
//    clk         - single clock, rising edge
//    reset       - asynchronous, active-low reset
//    impulse_in  - monitored pulse stream, synchronous to clk
//    clear       - synchronous clear of FSM state and statistics
//    locked      - high while LOCK_COUNT consecutive correct periods have been seen
//    period_err  - one-cycle strobe: measured period differs from EXPECTED_PERIOD
//    timeout     - one-cycle strobe: no edge for TIMEOUT cycles after a reference edge
//    period_out  - last measured period in cycles
//    pulse_count - number of detected rising edges, wraps at 16 bits
module impulse_monitor #(
   parameter int EXPECTED_PERIOD = 6,
   parameter int LOCK_COUNT      = 3,
   parameter int TIMEOUT         = 12,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             impulse_in,
   input  logic             clear,
   output logic             locked,
   output logic             period_err,
   output logic             timeout,
   output logic [CNT_W-1:0] period_out,
   output logic [15:0]      pulse_count
);

   // good_cnt must be able to hold LOCK_COUNT itself (saturation value)
   localparam int GC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            prev;
   logic            pulse_edge;
   logic [CNT_W-1:0] ivl;
   logic [GC_W-1:0] good_cnt;
   logic [GC_W-1:0] good_cnt_nxt;
   logic            period_hit;
   logic            gap_expired;
   logic            ivl_sat;
   logic            err_nxt;
   logic            to_nxt;
   logic            meas_load;

   // A multi-cycle high level produces only one edge
   assign pulse_edge = impulse_in & ~prev;

   // ivl counts cycles since the previous edge: at an edge it holds the period
   assign period_hit  = (int'(ivl) == EXPECTED_PERIOD);
   assign gap_expired = (int'(ivl) >= TIMEOUT);
   assign ivl_sat     = (ivl == {CNT_W{1'b1}});

   assign locked = (state == LOCKED);

   //---------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   //---------------------------------------------------------------------
   // FSM next-state and per-edge decisions
   //---------------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      err_nxt      = 1'b0;
      to_nxt       = 1'b0;
      meas_load    = 1'b0;

      if (clear) begin
         state_nxt    = IDLE;
         good_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               // First edge only establishes the reference; nothing measured
               if (pulse_edge) begin
                  state_nxt    = MEASURE;
                  good_cnt_nxt = '0;
               end
            end
            MEASURE, LOCKED: begin
               // An edge wins over a simultaneous timeout threshold
               if (pulse_edge) begin
                  meas_load = 1'b1;
                  if (period_hit) begin
                     if (int'(good_cnt) < LOCK_COUNT) begin
                        good_cnt_nxt = good_cnt + 1'b1;
                     end
                     if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
                        state_nxt = LOCKED;
                     end
                  end else begin
                     err_nxt      = 1'b1;
                     good_cnt_nxt = '0;
                     state_nxt    = MEASURE;
                  end
               end else if (gap_expired) begin
                  to_nxt       = 1'b1;
                  good_cnt_nxt = '0;
                  state_nxt    = IDLE;
               end
            end
            default: begin
               state_nxt    = IDLE;
               good_cnt_nxt = '0;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------
   // Datapath: edge history, interval counter, statistics, strobes
   //---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev        <= 1'b0;
         ivl         <= '0;
         good_cnt    <= '0;
         period_err  <= 1'b0;
         timeout     <= 1'b0;
         period_out  <= '0;
         pulse_count <= '0;
      end else begin
         // prev tracks the input even during clear so a level held high
         // across clear is not seen as a fresh edge afterwards
         prev       <= impulse_in;
         good_cnt   <= good_cnt_nxt;
         period_err <= err_nxt;
         timeout    <= to_nxt;

         if (clear) begin
            ivl         <= '0;
            period_out  <= '0;
            pulse_count <= '0;
         end else begin
            if (pulse_edge) begin
               ivl         <= CNT_W'(1);
               pulse_count <= pulse_count + 16'd1;
            end else if (!ivl_sat) begin
               ivl <= ivl + 1'b1;
            end

            if (meas_load) begin
               period_out <= ivl;
            end
         end
      end
   end

endmodule

// File: doc/impulse_monitor.md
IMPULSE_MONITOR -- requirements
Module: impulse_monitor

Interface
REQ-001 The block SHALL have parameter EXPECTED_PERIOD, default 6, the nominal cycles between input pulse rising edges.
REQ-002 The block SHALL have parameter LOCK_COUNT, default 3, the consecutive correct periods needed to declare lock.
REQ-003 The block SHALL have parameter TIMEOUT, default 12, the gap length in cycles that declares a lost pulse stream.
REQ-004 The block SHALL have parameter CNT_W, default 8, the width of the interval counter and period_out.
REQ-005 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port impulse_in  input  1  the pulse stream to monitor, synchronous to clk.
REQ-008 The block SHALL have port clear  input  1  synchronous clear of state and statistics.
REQ-009 The block SHALL have port locked  output  1  high while the stream has had LOCK_COUNT consecutive correct periods.
REQ-010 The block SHALL have port period_err  output  1  one-cycle strobe for a measured period other than EXPECTED_PERIOD.
REQ-011 The block SHALL have port timeout  output  1  one-cycle strobe when the gap reaches TIMEOUT.
REQ-012 The block SHALL have port period_out  output  CNT_W  last measured period in cycles.
REQ-013 The block SHALL have port pulse_count  output  16  count of detected rising edges.

Function
REQ-014 Edge detection: the block SHALL register impulse_in as prev; edge = impulse_in & ~prev; a multi-cycle high counts as one edge.
REQ-015 The interval counter ivl SHALL load 1 on an edge, otherwise increment, and saturate at 2^CNT_W-1.
REQ-016 The FSM SHALL have three states: IDLE (no reference edge), MEASURE (reference edge seen, not locked), and LOCKED.
REQ-017 In IDLE, an edge SHALL move the FSM to MEASURE, clear good_cnt, increment pulse_count, and leave period_out unchanged (no measurement).
REQ-018 In MEASURE or LOCKED, an edge SHALL load period_out with ivl (cycles since previous edge) on the next clock edge and increment pulse_count.
REQ-019 If ivl == EXPECTED_PERIOD on an edge, good_cnt SHALL increment (saturating at LOCK_COUNT); on reaching LOCK_COUNT the FSM SHALL enter LOCKED.
REQ-020 If ivl != EXPECTED_PERIOD on an edge, period_err SHALL pulse for exactly one cycle, good_cnt SHALL clear, and the FSM SHALL move LOCKED->MEASURE or stay in MEASURE.
REQ-021 In MEASURE or LOCKED, if ivl reaches TIMEOUT with no edge, timeout SHALL pulse for exactly one cycle, the FSM SHALL go to IDLE, and good_cnt SHALL clear.
REQ-022 If an edge and the timeout threshold coincide, the edge SHALL take priority and be treated as a measured period (REQ-018..020).
REQ-023 locked SHALL be registered and equal to (state == LOCKED).
REQ-024 pulse_count SHALL wrap from 16'hFFFF to 0.
REQ-025 clear SHALL override impulse_in: next cycle state=IDLE, good_cnt=0, ivl=0, period_out=0, pulse_count=0, strobes low; prev still samples impulse_in.
REQ-026 Latency: all outputs SHALL be registered and update one clock after the triggering edge cycle.

Reset
REQ-027 While reset is low, the block SHALL immediately force state=IDLE, prev=0, ivl=0, good_cnt=0, locked=0, period_err=0, timeout=0, period_out=0, pulse_count=0.
REQ-028 After reset deasserts mid-stream, the first edge SHALL be treated as an IDLE edge (no period measured).

Verification
REQ-029 Pulses every 6 cycles, defaults -> first edge gives pulse_count=1 and no period; after 3 further edges period_out=6 and locked=1; no period_err.
REQ-030 Locked stream then one gap of 5 -> period_out=5, one-cycle period_err, locked=0; 3 more correct periods -> locked=1.
REQ-031 Stop pulses when locked -> timeout strobes once 12 cycles after the last edge, locked=0, state IDLE; the next edge produces no period_err.
REQ-032 impulse_in held high 4 cycles, repeating every 6 -> each high run counts once; period_out=6.
REQ-033 Reset low for 1 cycle mid-lock, and separately clear for 1 cycle -> all outputs 0 next cycle; relock requires 1+3 edges.
REQ-034 pulse_count preset near wrap via 65536 edges -> reads 16'hFFFF then 0.
